// File: rtl/phy_types_pkg.sv
// Shared PHY transmit types: word/id types, encoder and UART selects,
// and the transmit scheduler's state and context encodings.
package phy_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [1:0]  pkt_id_t;

  localparam int NUM_RESEND = 4;
  // Clear vector layout: {resend[3:0], ack, nack}
  localparam int CLR_W      = 2 + NUM_RESEND;

  typedef enum logic [3:0] {
    START_PACKET_SEL   = 4'd0,
    END_PACKET_SEL     = 4'd1,
    DATA_SEL           = 4'd2,
    ACK_SEL            = 4'd3,
    NACK_SEL           = 4'd4,
    RESEND_PACKET0_SEL = 4'd5,
    RESEND_PACKET1_SEL = 4'd6,
    RESEND_PACKET2_SEL = 4'd7,
    RESEND_PACKET3_SEL = 4'd8
  } comma_sel_t;

  typedef enum logic [1:0] {
    NADA                = 2'd0,
    SELECT_COMMA_1_FLIT = 2'd1,
    SELECT_COMMA_DATA   = 2'd2
  } comma_length_sel_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} tx_sched_state_t;

  typedef enum logic [1:0] {CTX_CTRL, CTX_START, CTX_DATA, CTX_END} tx_ctx_t;

  // Map a packet id onto its resend comma.
  function automatic comma_sel_t resend_sel(input pkt_id_t id);
    case (id)
      2'd0:    return RESEND_PACKET0_SEL;
      2'd1:    return RESEND_PACKET1_SEL;
      2'd2:    return RESEND_PACKET2_SEL;
      default: return RESEND_PACKET3_SEL;
    endcase
  endfunction

endpackage

// File: rtl/tx_ctrl_arbiter.sv
// Fixed-priority pick among pending control commas:
// NACK > ACK > resend (lowest id first). Resend can be masked off while
// a packet is in flight.
module tx_ctrl_arbiter
  import phy_types_pkg::*;
(
  input  logic                  i_nack_p,
  input  logic                  i_ack_p,
  input  logic [NUM_RESEND-1:0] i_resend_p,
  input  logic                  i_resend_en,
  output logic                  o_grant,
  output comma_sel_t            o_sel,
  output logic [CLR_W-1:0]      o_clr
);

  // Priority encode the pending flags into a grant, comma and one-hot clear.
  always_comb begin
    o_grant = 1'b0;
    o_sel   = NACK_SEL;
    o_clr   = '0;
    if (i_nack_p) begin
      o_grant  = 1'b1;
      o_sel    = NACK_SEL;
      o_clr[0] = 1'b1;
    end else if (i_ack_p) begin
      o_grant  = 1'b1;
      o_sel    = ACK_SEL;
      o_clr[1] = 1'b1;
    end else if (i_resend_en) begin
      for (int k = 0; k < NUM_RESEND; k++) begin
        if (i_resend_p[k] && !o_grant) begin
          o_grant      = 1'b1;
          o_sel        = resend_sel(pkt_id_t'(k));
          o_clr[2 + k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/phy_tx_scheduler.sv
// PHY transmit scheduler: arbitrates control commas and the packet data
// stream onto the encoder/UART, one flit at a time, waiting for tx_done
// between flits. Packets are framed START, DATA..., END.
module phy_tx_scheduler
  import phy_types_pkg::*;
#(
  parameter int MAX_WORDS = 8,
  parameter int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  word_t             data_word,
  input  logic              data_last,
  output logic              data_ready,
  input  logic              ack_req,
  input  logic              nack_req,
  input  logic              resend_req,
  input  pkt_id_t           resend_id,
  output logic              tx_start,
  output comma_sel_t        tx_comma_sel,
  output comma_length_sel_t tx_length_sel,
  output word_t             tx_word,
  input  logic              tx_done,
  output logic              busy,
  output logic              err_overlength
);

  tx_sched_state_t   r_state;
  tx_ctx_t           r_ctx;
  logic              r_in_pkt;
  logic              r_last;
  logic [CW-1:0]     r_count;
  logic              r_done_seen;
  logic              r_nack_p;
  logic              r_ack_p;
  logic [NUM_RESEND-1:0] r_resend_p;
  logic [CLR_W-1:0]  r_clr;
  logic              r_tx_start;
  logic              r_data_ready;
  comma_sel_t        r_comma_sel;
  comma_length_sel_t r_length_sel;
  word_t             r_tx_word;
  logic              r_err;

  logic              w_grant;
  comma_sel_t        w_ctrl_sel;
  logic [CLR_W-1:0]  w_ctrl_clr;
  logic              w_arb;
  logic              w_load;
  logic              w_overlong;
  tx_ctx_t           w_ctx;
  comma_sel_t        w_sel;
  comma_length_sel_t w_len;
  logic [CLR_W-1:0]  w_clr;
  logic [CLR_W-1:0]  w_issue_clr;
  logic [NUM_RESEND-1:0] w_resend_set;

  // Resend is held back while a packet is open so it lands after END.
  tx_ctrl_arbiter u_arb (
    .i_nack_p    (r_nack_p),
    .i_ack_p     (r_ack_p),
    .i_resend_p  (r_resend_p),
    .i_resend_en (!r_in_pkt),
    .o_grant     (w_grant),
    .o_sel       (w_ctrl_sel),
    .o_clr       (w_ctrl_clr)
  );

  // Decide which flit (if any) to load at this arbitration point.
  always_comb begin
    w_arb      = (r_state == IDLE) || ((r_state == WAIT) && r_done_seen);
    w_load     = 1'b0;
    w_overlong = 1'b0;
    w_ctx      = CTX_CTRL;
    w_sel      = START_PACKET_SEL;
    w_len      = NADA;
    w_clr      = '0;
    if (w_arb) begin
      if (w_grant) begin
        w_load = 1'b1;
        w_ctx  = CTX_CTRL;
        w_sel  = w_ctrl_sel;
        w_len  = SELECT_COMMA_1_FLIT;
        w_clr  = w_ctrl_clr;
      end else if (!r_in_pkt) begin
        if (data_valid) begin
          w_load = 1'b1;
          w_ctx  = CTX_START;
          w_sel  = START_PACKET_SEL;
          w_len  = SELECT_COMMA_1_FLIT;
        end
      end else if (r_last || (r_count == CW'(MAX_WORDS))) begin
        w_load     = 1'b1;
        w_overlong = !r_last;
        w_ctx      = CTX_END;
        w_sel      = END_PACKET_SEL;
        w_len      = SELECT_COMMA_1_FLIT;
      end else if (data_valid) begin
        w_load = 1'b1;
        w_ctx  = CTX_DATA;
        w_sel  = DATA_SEL;
        w_len  = SELECT_COMMA_DATA;
      end
    end
  end

  // Pending-flag set/clear terms; a clear only fires on a control flit's issue.
  always_comb begin
    w_issue_clr  = ((r_state == ISSUE) && (r_ctx == CTX_CTRL)) ? r_clr : '0;
    w_resend_set = resend_req ? (NUM_RESEND'(1) << resend_id) : '0;
  end

  // Pending request flags; a new request wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nack_p   <= 1'b0;
      r_ack_p    <= 1'b0;
      r_resend_p <= '0;
    end else begin
      r_nack_p   <= nack_req | (r_nack_p & ~w_issue_clr[0]);
      r_ack_p    <= ack_req  | (r_ack_p  & ~w_issue_clr[1]);
      r_resend_p <= w_resend_set | (r_resend_p & ~w_issue_clr[CLR_W-1:2]);
    end
  end

  // Scheduler FSM with registered encoder/UART outputs and packet context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ctx        <= CTX_CTRL;
      r_in_pkt     <= 1'b0;
      r_last       <= 1'b0;
      r_count      <= '0;
      r_done_seen  <= 1'b0;
      r_clr        <= '0;
      r_tx_start   <= 1'b0;
      r_data_ready <= 1'b0;
      r_comma_sel  <= START_PACKET_SEL;
      r_length_sel <= NADA;
      r_tx_word    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_tx_start   <= 1'b0;
      r_data_ready <= 1'b0;
      unique case (r_state)
        IDLE, WAIT: begin
          if ((r_state == WAIT) && tx_done) r_done_seen <= 1'b1;
          if (w_load) begin
            r_state      <= ISSUE;
            r_done_seen  <= 1'b0;
            r_tx_start   <= 1'b1;
            r_ctx        <= w_ctx;
            r_comma_sel  <= w_sel;
            r_length_sel <= w_len;
            r_clr        <= w_clr;
            unique case (w_ctx)
              CTX_START: r_in_pkt <= 1'b1;
              CTX_DATA: begin
                r_tx_word    <= data_word;
                r_data_ready <= 1'b1;
                r_last       <= data_last;
                r_count      <= r_count + CW'(1);
              end
              CTX_END: begin
                r_in_pkt <= 1'b0;
                r_count  <= '0;
                r_last   <= 1'b0;
                if (w_overlong) r_err <= 1'b1;
              end
              default: ;
            endcase
          end else if (w_arb && (r_state == WAIT) && !r_in_pkt) begin
            r_state     <= IDLE;
            r_done_seen <= 1'b0;
          end
        end
        ISSUE:   r_state <= WAIT;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign tx_start       = r_tx_start;
  assign data_ready     = r_data_ready;
  assign tx_comma_sel   = r_comma_sel;
  assign tx_length_sel  = r_length_sel;
  assign tx_word        = r_tx_word;
  assign busy           = (r_state != IDLE);
  assign err_overlength = r_err;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Scoreboard bench for phy_tx_scheduler: stimulus pushes expected flits,
// a monitor pops and compares on every tx_start, a UART model returns
// tx_done three cycles after each launch.
module tb_phy_tx_scheduler;
  import phy_types_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              data_valid;
  word_t             data_word;
  logic              data_last;
  logic              data_ready;
  logic              ack_req;
  logic              nack_req;
  logic              resend_req;
  pkt_id_t           resend_id;
  logic              tx_start;
  comma_sel_t        tx_comma_sel;
  comma_length_sel_t tx_length_sel;
  word_t             tx_word;
  logic              tx_done;
  logic              busy;
  logic              err_overlength;

  phy_tx_scheduler #(.MAX_WORDS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_valid     (data_valid),
    .data_word      (data_word),
    .data_last      (data_last),
    .data_ready     (data_ready),
    .ack_req        (ack_req),
    .nack_req       (nack_req),
    .resend_req     (resend_req),
    .resend_id      (resend_id),
    .tx_start       (tx_start),
    .tx_comma_sel   (tx_comma_sel),
    .tx_length_sel  (tx_length_sel),
    .tx_word        (tx_word),
    .tx_done        (tx_done),
    .busy           (busy),
    .err_overlength (err_overlength)
  );

  always #5 clk = ~clk;

  typedef struct {
    comma_sel_t        sel;
    comma_length_sel_t len;
    word_t             word;
  } exp_t;

  typedef struct {
    word_t w;
    logic  l;
  } src_t;

  exp_t exp_q[$];
  src_t src_q[$];

  int n_vec   = 0;
  int n_err   = 0;
  int n_ready = 0;
  int done_cnt = 0;
  bit uart_kill  = 1'b0;
  bit stray_done = 1'b0;
  bit src_hold   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic exp_ctrl(input comma_sel_t s);
    exp_t e;
    e.sel = s; e.len = SELECT_COMMA_1_FLIT; e.word = '0;
    exp_q.push_back(e);
  endtask

  task automatic exp_data(input word_t w);
    exp_t e;
    e.sel = DATA_SEL; e.len = SELECT_COMMA_DATA; e.word = w;
    exp_q.push_back(e);
  endtask

  task automatic src_push(input word_t w, input logic l);
    src_t s;
    s.w = w; s.l = l;
    src_q.push_back(s);
  endtask

  // Monitor: every launched flit is compared against the scoreboard head.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          check("tx_start_unexpected", 32'(tx_start), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_comma_sel", 32'(tx_comma_sel), 32'(e.sel));
          check("tx_length_sel", 32'(tx_length_sel), 32'(e.len));
          if (e.sel == DATA_SEL) check("tx_word", tx_word, e.word);
          check("data_ready_with_start", 32'(data_ready), 32'(e.sel == DATA_SEL));
        end
      end else if (data_ready) begin
        check("data_ready_without_start", 32'(data_ready), 32'd0);
      end
      if (data_ready) n_ready++;
    end
  end

  // Data source: present the queue head, pop it on data_ready.
  always @(negedge clk) begin : source
    if (data_ready && src_q.size() > 0) void'(src_q.pop_front());
    if (src_q.size() > 0 && !src_hold) begin
      data_valid = 1'b1;
      data_word  = src_q[0].w;
      data_last  = src_q[0].l;
    end else begin
      data_valid = 1'b0;
      data_word  = '0;
      data_last  = 1'b0;
    end
  end

  // UART model: tx_done three cycles after each tx_start.
  always @(negedge clk) begin : uart
    tx_done = 1'b0;
    if (uart_kill) begin
      done_cnt = 0;
    end else if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) tx_done = 1'b1;
    end
    if (stray_done) tx_done = 1'b1;
    if (tx_start && !rst && !uart_kill) done_cnt = 3;
  end

  task automatic drain(input bit need_idle);
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("drain_timeout");
      exp_q.delete();
    end
    repeat (6) @(negedge clk);
    if (need_idle) check("busy_after_drain", 32'(busy), 32'd0);
  endtask

  task automatic wait_data_start();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tx_start && tx_comma_sel == DATA_SEL) && n < 200);
    if (n >= 200) timeout_fail("wait_data_start");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_tx_comma_sel"}, 32'(tx_comma_sel), 32'(START_PACKET_SEL));
    check({tag, "_tx_length_sel"}, 32'(tx_length_sel), 32'(NADA));
    check({tag, "_tx_word"}, tx_word, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_overlength"}, 32'(err_overlength), 32'd0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r0;
    int starts;
    rst = 1'b1;
    ack_req = 1'b0; nack_req = 1'b0; resend_req = 1'b0; resend_id = '0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single two-word packet.
    r0 = n_ready;
    exp_ctrl(START_PACKET_SEL);
    exp_data(32'hDEADBEEF);
    exp_data(32'h12345678);
    exp_ctrl(END_PACKET_SEL);
    src_push(32'hDEADBEEF, 1'b0);
    src_push(32'h12345678, 1'b1);
    drain(1'b1);
    check("data_ready_pulses", 32'(n_ready - r0), 32'd2);

    // ACK and NACK together while idle: NACK first.
    exp_ctrl(NACK_SEL);
    exp_ctrl(ACK_SEL);
    ack_req = 1'b1; nack_req = 1'b1;
    @(negedge clk);
    ack_req = 1'b0; nack_req = 1'b0;
    drain(1'b1);

    // ACK inserted mid-packet, resends deferred until after END.
    exp_ctrl(START_PACKET_SEL);
    exp_data(32'hA0000001);
    exp_ctrl(ACK_SEL);
    exp_data(32'hA0000002);
    exp_data(32'hA0000003);
    exp_data(32'hA0000004);
    exp_ctrl(END_PACKET_SEL);
    exp_ctrl(RESEND_PACKET0_SEL);
    exp_ctrl(RESEND_PACKET2_SEL);
    src_push(32'hA0000001, 1'b0);
    src_push(32'hA0000002, 1'b0);
    src_push(32'hA0000003, 1'b0);
    src_push(32'hA0000004, 1'b1);
    wait_data_start();
    ack_req = 1'b1; resend_req = 1'b1; resend_id = 2'd2;
    @(negedge clk);
    ack_req = 1'b0; resend_id = 2'd0;
    @(negedge clk);
    resend_req = 1'b0;
    drain(1'b1);

    // Ten words without last: END forced after eight.
    check("err_before_overlength", 32'(err_overlength), 32'd0);
    exp_ctrl(START_PACKET_SEL);
    for (int i = 1; i <= 8; i++) exp_data(32'hB000_0000 + 32'(i));
    exp_ctrl(END_PACKET_SEL);
    exp_ctrl(START_PACKET_SEL);
    exp_data(32'hB000_0009);
    exp_data(32'hB000_000A);
    for (int i = 1; i <= 10; i++) src_push(32'hB000_0000 + 32'(i), 1'b0);
    drain(1'b0);
    check("err_overlength_set", 32'(err_overlength), 32'd1);
    check("busy_open_packet", 32'(busy), 32'd1);
    exp_data(32'hB000_000B);
    exp_ctrl(END_PACKET_SEL);
    src_push(32'hB000_000B, 1'b1);
    drain(1'b1);
    check("err_overlength_sticky", 32'(err_overlength), 32'd1);

    // Data stall mid-packet: no launches until data returns.
    exp_ctrl(START_PACKET_SEL);
    exp_data(32'hC0000001);
    src_push(32'hC0000001, 1'b0);
    drain(1'b0);
    starts = 0;
    repeat (9) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    check("stall_no_tx_start", 32'(starts), 32'd0);
    check("stall_busy", 32'(busy), 32'd1);
    exp_data(32'hC0000002);
    exp_ctrl(END_PACKET_SEL);
    src_push(32'hC0000002, 1'b1);
    drain(1'b1);

    // Reset during WAIT of a DATA flit with ACK pending.
    exp_ctrl(START_PACKET_SEL);
    exp_data(32'hD0000001);
    src_push(32'hD0000001, 1'b0);
    wait_data_start();
    ack_req = 1'b1;
    @(negedge clk);
    ack_req = 1'b0;
    uart_kill = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midflit_rst");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    src_q.delete();
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    stray_done = 1'b0;
    starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_start) starts++;
    end
    check("stray_done_no_tx_start", 32'(starts), 32'd0);
    check("stray_done_busy", 32'(busy), 32'd0);
    uart_kill = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phy_tx_scheduler.md
Name: phy_tx_scheduler

Overview:
- Sequences the PHY transmit path (8b10b encoder + UART) and arbitrates it between three requesters:
  - the packet data stream;
  - ACK/NACK requests from the receive side;
  - resend requests for packet ids 0-3.
- Emits the comma/data selection and word for each flit, then waits for the UART to finish before issuing the next one.
- Sits between the link-layer flit buffer and the encoder.

Parameters:
- MAX_WORDS, 8, maximum data words per packet before END is forced.
- CW, $clog2(MAX_WORDS+1), word-counter width (derived).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- data_valid  in  1  data word available
- data_word  in  word_t  data word
- data_last  in  1  word is the last of its packet
- data_ready  out  1  one-cycle pop pulse: word captured
- ack_req  in  1  pulse: send ACK comma
- nack_req  in  1  pulse: send NACK comma
- resend_req  in  1  pulse: send resend comma
- resend_id  in  pkt_id_t  packet id for resend_req
- tx_start  out  1  one-cycle pulse: launch flit
- tx_comma_sel  out  comma_sel_t  encoder select
- tx_length_sel  out  comma_length_sel_t  UART length select
- tx_word  out  word_t  data word to encoder
- tx_done  in  1  pulse: UART finished current flit
- busy  out  1  state != IDLE
- err_overlength  out  1  sticky: END forced by MAX_WORDS

Behaviour:
- Reset (async, rst=1) forces:
  - state IDLE, tx_start=0, data_ready=0;
  - tx_comma_sel=START_PACKET_SEL, tx_length_sel=NADA, tx_word=0;
  - all pending flags cleared, word count 0, err_overlength=0.
  - Reset mid-flit abandons the flit; any later tx_done is ignored in IDLE.
- Pending flags:
  - ack_p, nack_p: 1 bit each. resend_p: 4-bit mask indexed by resend_id.
  - Set on request pulse; cleared when the corresponding comma's tx_start issues.
  - A set and a clear on the same cycle: the set wins and the flag stays 1.
- Priority at every arbitration point: nack_p > ack_p > resend_p (lowest id first) > data_valid.
- States: IDLE, ISSUE, WAIT; ctx register in {CTRL, START, DATA, END}; in_pkt flag.
- IDLE:
  - Any pending flag, or data_valid, causes ISSUE on the next cycle.
  - Control flags take precedence; data_valid selects ctx=START.
- ISSUE (exactly one cycle):
  - tx_start=1. Output registers were loaded on entry and are then held stable until tx_done.
  - Next state is WAIT.
- Encodings per ctx:
  - CTRL: NACK_SEL / ACK_SEL / RESEND_PACKETk_SEL, length SELECT_COMMA_1_FLIT.
  - START: START_PACKET_SEL, SELECT_COMMA_1_FLIT; sets in_pkt.
  - DATA: DATA_SEL, SELECT_COMMA_DATA, tx_word=data_word. data_ready pulses on the load cycle; data_last is captured; count increments.
  - END: END_PACKET_SEL, SELECT_COMMA_1_FLIT; clears in_pkt and count.
- WAIT: hold until tx_done, then arbitrate:
  - !in_pkt: same rule as IDLE, or go to IDLE if nothing is pending.
  - in_pkt: nack_p/ack_p are inserted between words. Resend is deferred until after END.
  - in_pkt, then: last word sent -> END. count==MAX_WORDS -> END and set err_overlength. data_valid -> DATA. Otherwise stay in WAIT (stall mid-packet).
- Latency: IDLE request at cycle t -> tx_start at t+2 (load at t+1). tx_done at t -> next tx_start at t+2.
- tx_done outside WAIT is ignored.

Decomposition:
- Add to phy_types_pkg:
  - tx_sched_state_t enum {IDLE, ISSUE, WAIT};
  - tx_ctx_t enum {CTX_CTRL, CTX_START, CTX_DATA, CTX_END}.
- Sub-module tx_ctrl_arbiter: combinational priority pick over nack_p / ack_p / resend_p. Outputs grant, comma_sel_t, and a one-hot clear vector.

Test Plan:
- Single packet: data_valid with words 0xDEADBEEF, 0x12345678 (last); tx_done returned 3 cycles after each tx_start -> tx_comma_sel sequence START, DATA, DATA, END; tx_word values match; data_ready pulses twice; busy drops after the final tx_done.
- ack_req and nack_req in the same cycle while idle -> NACK_SEL then ACK_SEL, one tx_start each.
- resend_req for ids 2 and 0 during a 4-word packet, plus ack_req after word 1 -> ACK inserted between words 1 and 2; after END, RESEND_PACKET0_SEL then RESEND_PACKET2_SEL.
- MAX_WORDS=8 and 10 words with no data_last -> after 8 DATA flits END is forced and err_overlength=1; the 9th word starts a new packet with START.
- rst asserted during WAIT of a DATA flit, with ack_p pending -> all outputs at reset values immediately; a later stray tx_done produces no tx_start.
- data_valid drops mid-packet for 5 cycles -> remains in WAIT with no tx_start; resumes with DATA on the next data_valid.
